// File: rtl/tusca_arbitro_serial.sv
// Arbitrates the TUSCA serial transmitter between measurement frames and config
// acknowledge frames, then sends the winning frame one byte per tx handshake.
module tusca_arbitro_serial #(
    parameter int unsigned N_BYTES_MED    = 4,
    parameter int unsigned N_BYTES_CFG    = 2,
    parameter int unsigned TIMEOUT_CICLOS = 50000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       req_medida,
    input  logic [8*N_BYTES_MED-1:0]   frame_medida,
    input  logic                       req_config,
    input  logic [8*N_BYTES_CFG-1:0]   frame_config,
    output logic                       tx_partida,
    output logic [7:0]                 tx_dados,
    input  logic                       tx_pronto,
    output logic                       pronto_medida_tx,
    output logic                       pronto_config_tx,
    output logic                       erro_tx,
    output logic                       ocupado,
    output logic [3:0]                 db_estado
);

    localparam int unsigned W_MED = 8 * N_BYTES_MED;
    localparam int unsigned W_CFG = 8 * N_BYTES_CFG;
    localparam int unsigned W_CNT = $clog2(TIMEOUT_CICLOS);
    localparam int unsigned W_IDX = (N_BYTES_MED > 1) ? $clog2(N_BYTES_MED) : 1;

    typedef enum logic [3:0] {
        OCIOSO      = 4'd0,
        CAPTURA     = 4'd1,
        ENVIA_BYTE  = 4'd2,
        ESPERA_BYTE = 4'd3,
        PROXIMO     = 4'd4,
        FIM         = 4'd5,
        ERRO        = 4'd6
    } estado_t;

    typedef enum logic {
        DONO_MEDIDA = 1'b0,
        DONO_CONFIG = 1'b1
    } dono_t;

    estado_t            estado_q, estado_d;
    logic               pend_medida_q, pend_medida_d;
    logic               pend_config_q, pend_config_d;
    logic [W_MED-1:0]   buf_medida_q, buf_medida_d;
    logic [W_CFG-1:0]   buf_config_q, buf_config_d;
    logic [W_MED-1:0]   shift_q, shift_d;
    logic [W_IDX-1:0]   idx_q, idx_d;
    logic [W_IDX-1:0]   ultimo_q, ultimo_d;
    logic [W_CNT-1:0]   cnt_q, cnt_d;
    dono_t              dono_q, dono_d;
    dono_t              ultimo_dono_q, ultimo_dono_d;
    dono_t              vencedor_q, vencedor_d;

    logic               tx_partida_d;
    logic [7:0]         tx_dados_d;
    logic               pronto_medida_d;
    logic               pronto_config_d;
    logic               erro_d;
    logic               ocupado_d;
    logic [3:0]         db_estado_d;

    // State register
    always_ff @(posedge clock) begin
        if (reset) estado_q <= OCIOSO;
        else       estado_q <= estado_d;
    end

    // Frame buffers, shift register, byte index and timeout counter
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_medida_q <= 1'b0;
            pend_config_q <= 1'b0;
            buf_medida_q  <= '0;
            buf_config_q  <= '0;
            shift_q       <= '0;
            idx_q         <= '0;
            ultimo_q      <= '0;
            cnt_q         <= '0;
            dono_q        <= DONO_CONFIG;
            ultimo_dono_q <= DONO_CONFIG;
            vencedor_q    <= DONO_MEDIDA;
        end else begin
            pend_medida_q <= pend_medida_d;
            pend_config_q <= pend_config_d;
            buf_medida_q  <= buf_medida_d;
            buf_config_q  <= buf_config_d;
            shift_q       <= shift_d;
            idx_q         <= idx_d;
            ultimo_q      <= ultimo_d;
            cnt_q         <= cnt_d;
            dono_q        <= dono_d;
            ultimo_dono_q <= ultimo_dono_d;
            vencedor_q    <= vencedor_d;
        end
    end

    // Output registers, decoded from the state being entered
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_partida       <= 1'b0;
            tx_dados         <= '0;
            pronto_medida_tx <= 1'b0;
            pronto_config_tx <= 1'b0;
            erro_tx          <= 1'b0;
            ocupado          <= 1'b0;
            db_estado        <= '0;
        end else begin
            tx_partida       <= tx_partida_d;
            tx_dados         <= tx_dados_d;
            pronto_medida_tx <= pronto_medida_d;
            pronto_config_tx <= pronto_config_d;
            erro_tx          <= erro_d;
            ocupado          <= ocupado_d;
            db_estado        <= db_estado_d;
        end
    end

    // Next-state, datapath and output decode
    always_comb begin
        estado_d        = estado_q;
        pend_medida_d   = pend_medida_q;
        pend_config_d   = pend_config_q;
        buf_medida_d    = buf_medida_q;
        buf_config_d    = buf_config_q;
        shift_d         = shift_q;
        idx_d           = idx_q;
        ultimo_d        = ultimo_q;
        cnt_d           = cnt_q;
        dono_d          = dono_q;
        ultimo_dono_d   = ultimo_dono_q;
        vencedor_d      = vencedor_q;
        tx_partida_d    = 1'b0;
        tx_dados_d      = tx_dados;
        pronto_medida_d = 1'b0;
        pronto_config_d = 1'b0;
        erro_d          = 1'b0;
        ocupado_d       = 1'b0;
        db_estado_d     = 4'd0;

        case (estado_q)
            OCIOSO: begin
                if (pend_medida_q || pend_config_q) begin
                    estado_d = CAPTURA;
                    // Round-robin only matters when both sources wait
                    if (pend_medida_q && pend_config_q)
                        vencedor_d = (ultimo_dono_q == DONO_CONFIG) ? DONO_MEDIDA : DONO_CONFIG;
                    else
                        vencedor_d = pend_medida_q ? DONO_MEDIDA : DONO_CONFIG;
                end
            end
            CAPTURA: begin
                if (vencedor_q == DONO_MEDIDA) begin
                    shift_d       = buf_medida_q;
                    pend_medida_d = 1'b0;
                    ultimo_d      = W_IDX'(N_BYTES_MED - 1);
                end else begin
                    shift_d       = W_MED'(buf_config_q);
                    pend_config_d = 1'b0;
                    ultimo_d      = W_IDX'(N_BYTES_CFG - 1);
                end
                dono_d        = vencedor_q;
                ultimo_dono_d = vencedor_q;
                idx_d         = '0;
                estado_d      = ENVIA_BYTE;
            end
            ENVIA_BYTE: begin
                cnt_d    = '0;
                estado_d = ESPERA_BYTE;
            end
            ESPERA_BYTE: begin
                // A handshake in the timeout cycle still counts as success
                if (tx_pronto)
                    estado_d = (idx_q == ultimo_q) ? FIM : PROXIMO;
                else if (cnt_q == W_CNT'(TIMEOUT_CICLOS - 1))
                    estado_d = ERRO;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            PROXIMO: begin
                shift_d  = shift_q >> 8;
                idx_d    = idx_q + 1'b1;
                estado_d = ENVIA_BYTE;
            end
            FIM:     estado_d = OCIOSO;
            ERRO:    estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase

        // New requests always land in their buffer, even over a pending or just-granted frame
        if (req_medida) begin
            buf_medida_d  = frame_medida;
            pend_medida_d = 1'b1;
        end
        if (req_config) begin
            buf_config_d  = frame_config;
            pend_config_d = 1'b1;
        end

        if (estado_d == ENVIA_BYTE) begin
            tx_partida_d = 1'b1;
            tx_dados_d   = shift_d[7:0];
        end
        pronto_medida_d = (estado_d == FIM) && (dono_d == DONO_MEDIDA);
        pronto_config_d = (estado_d == FIM) && (dono_d == DONO_CONFIG);
        erro_d          = (estado_d == ERRO);
        ocupado_d       = (estado_d != OCIOSO);
        db_estado_d     = estado_d;
    end

endmodule
